// File: rtl/w_ptr_and_full.sv
// ----------------------------------------------------------------------------
// w_ptr_and_full
//
// Write-side pointer and flag logic of an asynchronous FIFO. It keeps the
// binary write count and publishes it to the read domain as a registered
// Gray pointer. It brings the read domain's Gray pointer in through a
// two-flop synchroniser and derives full, almost_full, occupancy and a
// sticky overflow flag from it. Every flag is pessimistic: a read seen late
// can only make the FIFO look fuller than it really is, never emptier.
//
// Parameters
//   ADDR_W    memory address width (depth = 2**ADDR_W); must be >= 2
//   AF_LEVEL  almost-full threshold in entries, 1 .. 2**ADDR_W
//
// Ports
//   wr_clk       write-domain clock, all state changes on its rising edge
//   wr_rst       synchronous active-low reset
//   wr_en        write request from the producer
//   ovf_clr      clears the sticky overflow flag
//   rq_rptr      Gray read pointer from the read domain (asynchronous)
//   wr_ptr       registered Gray write pointer to the read domain
//   wr_addr      binary memory write address for the current cycle
//   mem_we       memory write strobe (wr_en and not full), combinational
//   full         registered full flag
//   almost_full  registered flag, occupancy >= AF_LEVEL
//   wr_level     registered occupancy as seen from the write domain
//   overflow     sticky flag, set by a write attempt while full
// ----------------------------------------------------------------------------
module w_ptr_and_full #(
    parameter int ADDR_W   = 3,
    parameter int AF_LEVEL = 6
) (
    input  logic              wr_clk,
    input  logic              wr_rst,
    input  logic              wr_en,
    input  logic              ovf_clr,
    input  logic [ADDR_W:0]   rq_rptr,
    output logic [ADDR_W:0]   wr_ptr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              mem_we,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              overflow
);

    localparam int PW = ADDR_W + 1;

    // The write pointer is exactly one lap ahead of the read pointer when
    // the two top Gray bits differ and the rest match.
    localparam logic [PW-1:0] LAP_MASK  = {2'b11, {(PW-2){1'b0}}};
    localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wq1_rptr;
    logic [PW-1:0] wq2_rptr;
    logic [PW-1:0] wbin;

    logic [PW-1:0] wbin_next_s;
    logic [PW-1:0] wgray_next_s;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] level_next_s;
    logic          full_next_s;
    logic          ovf_set_s;

    // Next-state arithmetic for the write count, the flags and the write strobe.
    always_comb begin
        mem_we       = 1'b0;
        wbin_next_s  = wbin;
        wgray_next_s = '0;
        rbin_s       = '0;
        level_next_s = '0;
        full_next_s  = 1'b0;
        ovf_set_s    = 1'b0;

        mem_we       = wr_en & ~full;
        wbin_next_s  = wbin + {{(PW-1){1'b0}}, mem_we};
        wgray_next_s = bin2gray(wbin_next_s);
        // Only the second synchroniser stage may be decoded: wq1 can be
        // metastable.
        rbin_s       = gray2bin(wq2_rptr);
        level_next_s = wbin_next_s - rbin_s;
        full_next_s  = (wgray_next_s == (wq2_rptr ^ LAP_MASK));
        ovf_set_s    = wr_en & full;
    end

    assign wr_addr = wbin[ADDR_W-1:0];

    // Synchroniser, write count, Gray pointer and registered flags.
    always_ff @(posedge wr_clk) begin
        if (!wr_rst) begin
            wq1_rptr    <= '0;
            wq2_rptr    <= '0;
            wbin        <= '0;
            wr_ptr      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            wq1_rptr    <= rq_rptr;
            wq2_rptr    <= wq1_rptr;
            wbin        <= wbin_next_s;
            wr_ptr      <= wgray_next_s;
            full        <= full_next_s;
            almost_full <= (level_next_s >= AF_THRESH);
            wr_level    <= level_next_s;
            // A fresh overflow on the same edge as ovf_clr takes priority.
            overflow    <= ovf_set_s | (overflow & ~ovf_clr);
        end
    end

endmodule

// File: tb/tb_w_ptr_and_full.sv
// ----------------------------------------------------------------------------
// tb_w_ptr_and_full
//
// Self-checking bench for w_ptr_and_full (ADDR_W=3, AF_LEVEL=6). The
// reference model counts accepted writes and completed reads as plain
// integers. It sees the reader's count two edges late and derives the
// occupancy, flags and Gray pointer arithmetically from those counts.
// ----------------------------------------------------------------------------
module tb_w_ptr_and_full;

    logic       wr_clk = 1'b0;
    logic       wr_rst;
    logic       wr_en;
    logic       ovf_clr;
    logic [3:0] rq_rptr;
    logic [3:0] wr_ptr;
    logic [2:0] wr_addr;
    logic       mem_we;
    logic       full;
    logic       almost_full;
    logic [3:0] wr_level;
    logic       overflow;

    w_ptr_and_full #(
        .ADDR_W   (3),
        .AF_LEVEL (6)
    ) dut (
        .wr_clk      (wr_clk),
        .wr_rst      (wr_rst),
        .wr_en       (wr_en),
        .ovf_clr     (ovf_clr),
        .rq_rptr     (rq_rptr),
        .wr_ptr      (wr_ptr),
        .wr_addr     (wr_addr),
        .mem_we      (mem_we),
        .full        (full),
        .almost_full (almost_full),
        .wr_level    (wr_level),
        .overflow    (overflow)
    );

    always #5 wr_clk = ~wr_clk;

    int tests  = 0;
    int failed = 0;

    // Reference model state
    int  wtot;      // writes accepted since reset
    int  rtot;      // reads completed by the reader since reset
    int  m_lvl;
    bit  m_full;
    bit  m_af;
    bit  m_ovf;
    bit  m_valid;
    int  hist[$];   // reader counts in flight toward the write domain

    logic [3:0] prev_ptr;
    logic [3:0] fill_seq [8];

    function automatic logic [3:0] gray(input int n);
        int b;
        b = n % 16;
        return 4'(b ^ (b >> 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check the strobe, advance the model at
    // the rising edge, check all registered outputs at the falling edge.
    task automatic step(input bit we, input bit clr, input bit rst);
        bit old_full;
        int rs;
        wr_en   = we;
        ovf_clr = clr;
        wr_rst  = rst;
        rq_rptr = gray(rtot);
        #1;
        if (m_valid) chk("mem_we", 32'(mem_we), 32'(we & !m_full));
        @(posedge wr_clk);
        if (!rst) begin
            wtot    = 0;
            m_lvl   = 0;
            m_full  = 1'b0;
            m_af    = 1'b0;
            m_ovf   = 1'b0;
            hist    = '{0, 0};
            m_valid = 1'b1;
        end else begin
            old_full = m_full;
            if (we && !old_full) wtot++;
            rs = hist.pop_front();
            hist.push_back(rtot);
            m_lvl  = wtot - rs;
            m_full = (m_lvl == 8);
            m_af   = (m_lvl >= 6);
            m_ovf  = (we && old_full) || (m_ovf && !clr);
        end
        @(negedge wr_clk);
        chk("wr_ptr",      32'(wr_ptr),      32'(gray(wtot)));
        chk("wr_addr",     32'(wr_addr),     32'(wtot % 8));
        chk("full",        32'(full),        32'(m_full));
        chk("almost_full", 32'(almost_full), 32'(m_af));
        chk("wr_level",    32'(wr_level),    32'(m_lvl));
        chk("overflow",    32'(overflow),    32'(m_ovf));
    endtask

    initial begin
        fill_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                     4'b0111, 4'b0101, 4'b0100, 4'b1100};
        wtot     = 0;
        rtot     = 0;
        m_lvl    = 0;
        m_full   = 1'b0;
        m_af     = 1'b0;
        m_ovf    = 1'b0;
        m_valid  = 1'b0;
        hist     = '{0, 0};
        prev_ptr = 4'b0000;

        // Reset for two edges with a write request pending
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("rst_ptr",   32'(wr_ptr),   32'd0);
        chk("rst_level", 32'(wr_level), 32'd0);
        chk("rst_full",  32'(full),     32'd0);

        // Fill with the reader parked at zero
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b1);
            chk("fill_seq", 32'(wr_ptr), 32'(fill_seq[i]));
            if (i == 4) chk("af_below", 32'(almost_full), 32'd0);
            if (i == 5) chk("af_at6",   32'(almost_full), 32'd1);
            if (i == 6) chk("full_early", 32'(full), 32'd0);
        end
        chk("fill_full",  32'(full),     32'd1);
        chk("fill_level", 32'(wr_level), 32'd8);

        // Overflow set, clear, and set winning over clear
        step(1'b1, 1'b0, 1'b1);
        chk("ovf_ptr_hold", 32'(wr_ptr),   32'(4'b1100));
        chk("ovf_set",      32'(overflow), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        chk("ovf_clr",      32'(overflow), 32'd0);
        step(1'b1, 1'b1, 1'b1);
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        step(1'b0, 1'b1, 1'b1);

        // Drain one entry: seen on the third edge, not before
        rtot = 1;
        step(1'b0, 1'b0, 1'b1);
        chk("drain_e1_full", 32'(full), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("drain_e2_full", 32'(full), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("drain_e3_full",  32'(full),        32'd0);
        chk("drain_e3_level", 32'(wr_level),    32'd7);
        chk("drain_e3_af",    32'(almost_full), 32'd1);

        // Wrap: reader tracks the writer one cycle behind
        rtot = 0;
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            rtot     = wtot;
            prev_ptr = wr_ptr;
            step(1'b1, 1'b0, 1'b1);
            chk("wrap_onebit", 32'($countones(prev_ptr ^ wr_ptr)), 32'd1);
            chk("wrap_nofull", 32'(full), 32'd0);
        end
        chk("wrap_ptr",  32'(wr_ptr),  32'd0);
        chk("wrap_addr", 32'(wr_addr), 32'd0);

        // Mid-operation reset at level 5
        rtot = 0;
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
        chk("mid_level5", 32'(wr_level), 32'd5);
        step(1'b1, 1'b0, 1'b0);
        chk("mid_rst_ptr",   32'(wr_ptr),   32'd0);
        chk("mid_rst_level", 32'(wr_level), 32'd0);
        chk("mid_addr0",     32'(wr_addr),  32'd0);
        step(1'b1, 1'b0, 1'b1);
        chk("mid_level1", 32'(wr_level), 32'd1);

        // Randomised traffic with an occasional reset
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                rtot = 0;
                step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end else begin
                if (rtot < wtot && $urandom_range(0, 1) == 1) rtot++;
                step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
